pb_debounce: RTL

//  Debounces one active-low board pushbutton and produces the clean, single-cycle

---
 rtl/pb_debounce.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pb_debounce.sv
// ---------------------------------------------------------------------------
// pb_debounce
//   Debounces one active-low board pushbutton and turns accepted level changes
//   into clean single-cycle events for the LED blink stage in the same clock
//   domain. The raw button is brought in through a two-flop synchronizer. A
//   four-state FSM and a stability counter then qualify it. A toggle flag flips
//   on every accepted press.
//
//   Optional feature: define LONG_PRESS_EN to build the long-hold detector.
//   Without it, long_pulse is tied low and no long-hold logic exists.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   LONG_CYCLES      cycles held in PRESSED before long_pulse (LONG_PRESS_EN)
//
// Ports
//   clk            system clock
//   reset_n        synchronous, active-low reset
//   btn_n          raw asynchronous pushbutton, 0 = pressed
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe on an accepted press
//   release_pulse  one-cycle strobe on an accepted release
//   toggle_q       flips on every accepted press
//   long_pulse     one-cycle strobe on a long hold (0 when compiled out)
// ---------------------------------------------------------------------------
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int LONG_CYCLES     = 48_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_q,
  output logic long_pulse
);

  // The counter serves both the debounce window and the long-hold timer, so
  // it is sized for whichever of the two is larger.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  // The counter parks one past LONG_LAST after firing, so a press fires at most once.
  localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);
`endif

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic             sync1_r;
  logic             btn_sync_r;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             btn_level_r;
  logic             press_pulse_r;
  logic             release_pulse_r;
  logic             toggle_r;
`ifdef LONG_PRESS_EN
  logic             long_pulse_r;
`endif

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r    <= 1'b1;
      btn_sync_r <= 1'b1;
    end else begin
      sync1_r    <= btn_n;
      btn_sync_r <= sync1_r;
    end
  end

  // Debounce FSM, stability counter, event strobes and toggle flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      cnt_r           <= CNT_ZERO;
      btn_level_r     <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
      toggle_r        <= 1'b0;
`ifdef LONG_PRESS_EN
      long_pulse_r    <= 1'b0;
`endif
    end else begin
      // Strobes are high for one cycle only; later assignments override.
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
`ifdef LONG_PRESS_EN
      long_pulse_r    <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (!btn_sync_r) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= CNT_ZERO;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (btn_sync_r) begin
            state_r <= IDLE;
          end else if (cnt_r == DB_LAST) begin
            state_r       <= PRESSED;
            btn_level_r   <= 1'b1;
            press_pulse_r <= 1'b1;
            toggle_r      <= ~toggle_r;
            cnt_r         <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (btn_sync_r) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= CNT_ZERO;
          end else begin
`ifdef LONG_PRESS_EN
            if (cnt_r < LONG_LAST) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else if (cnt_r == LONG_LAST) begin
              long_pulse_r <= 1'b1;
              cnt_r        <= LONG_DONE;
            end else begin
              cnt_r <= cnt_r;
            end
`else
            cnt_r <= cnt_r;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (!btn_sync_r) begin
            // Bounce back to pressed; any long-hold timing starts over.
            state_r <= PRESSED;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DB_LAST) begin
            state_r         <= IDLE;
            btn_level_r     <= 1'b0;
            release_pulse_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign btn_level     = btn_level_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;
  assign toggle_q      = toggle_r;
`ifdef LONG_PRESS_EN
  assign long_pulse    = long_pulse_r;
`else
  assign long_pulse    = 1'b0;
`endif

endmodule
